// File: rtl/seq_det_pkg.sv
// Shared state encoding and sizing helpers for the programmable sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_LEN_DEFAULT = 8;

  // Width needed to hold a pattern length in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_window_match.sv
// Sliding history of accepted bits plus masked compare against the programmed pattern.
module seq_window_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      shift_en,
  input  logic                      clear,
  input  logic                      in_bit,
  input  logic [MAX_LEN-1:0]        pattern,
  input  logic [len_w(MAX_LEN)-1:0] len,
  output logic                      hit
);

  localparam int LW = len_w(MAX_LEN);
  localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN - 1);
  localparam logic [LW-1:0] ONE      = LW'(1);

  logic [MAX_LEN-2:0] history;
  logic [LW-1:0]      fill;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      need;
  logic               fill_ok;
  logic               bits_ok;

  // Candidate window: history with the bit being offered appended as the newest.
  always_comb begin
    window  = {history, in_bit};
    need    = len - ONE;
    fill_ok = (fill >= need);
    mask    = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    bits_ok = (((window ^ pattern) & mask) == {MAX_LEN{1'b0}});
    hit     = fill_ok & bits_ok;
  end

  // History shift register and saturating fill count; clear beats shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      history <= {(MAX_LEN-1){1'b0}};
      fill    <= {LW{1'b0}};
    end else if (clear) begin
      history <= {(MAX_LEN-1){1'b0}};
      fill    <= {LW{1'b0}};
    end else if (shift_en) begin
      history <= window[MAX_LEN-2:0];
      if (fill != FILL_MAX) begin
        fill <= fill + ONE;
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller: config registers, run FSM,
// valid/ready handshake and saturating match counter around seq_window_match.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cfg_we,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0] cfg_len,
  input  logic                      cfg_overlap,
  input  logic [CNT_W-1:0]          cfg_target,
  output logic                      cfg_err,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic                      in_bit,
  output logic                      in_ready,
  output logic                      match,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          match_count
);

  localparam int LW = len_w(MAX_LEN);
  localparam logic [LW-1:0]    LEN_MAX  = LW'(MAX_LEN);
  localparam logic [LW-1:0]    LEN_ONE  = LW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t             state;
  state_t             state_nxt;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      len;
  logic               overlap;
  logic [CNT_W-1:0]   target;
  logic [CNT_W-1:0]   count_inc;
  logic               accept;
  logic               start_go;
  logic               win_clear;
  logic               hit;
  logic               cfg_open;
  logic               cfg_legal;

  seq_window_match #(
    .MAX_LEN (MAX_LEN)
  ) u_window (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (accept),
    .clear    (win_clear),
    .in_bit   (in_bit),
    .pattern  (pattern),
    .len      (len),
    .hit      (hit)
  );

  // Handshake qualification, Mealy match, and next-state decode.
  always_comb begin
    accept    = in_valid & (state == ARMED);
    match     = accept & ~abort & hit;
    start_go  = start & ~abort & (state != ARMED);
    win_clear = start_go | (match & ~overlap);
    if (match && (match_count != CNT_MAX)) begin
      count_inc = match_count + CNT_ONE;
    end else begin
      count_inc = match_count;
    end
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start_go) begin
          state_nxt = ARMED;
        end else begin
          state_nxt = state;
        end
      end
      ARMED: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (match && (target != CNT_ZERO) && (count_inc == target)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ARMED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with busy/done flags taken straight from flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ARMED);
      done  <= (state_nxt == DONE);
    end
  end

  assign in_ready = busy;

  // Match counter: cleared by an accepted start, held across abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      match_count <= CNT_ZERO;
    end else if (start_go) begin
      match_count <= CNT_ZERO;
    end else begin
      match_count <= count_inc;
    end
  end

  assign cfg_open  = cfg_we & (state != ARMED);
  assign cfg_legal = (cfg_len >= LEN_ONE) && (cfg_len <= LEN_MAX);

  // Configuration registers; an illegal length leaves them untouched and flags cfg_err.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pattern <= {MAX_LEN{1'b0}};
      len     <= LEN_ONE;
      overlap <= 1'b1;
      target  <= CNT_ZERO;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_open & ~cfg_legal;
      if (cfg_open && cfg_legal) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
        target  <= cfg_target;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based reference model.
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rstn;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               in_valid;
  logic               in_bit;
  logic               in_ready;
  logic               match;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   match_count;

  int n_tests = 0;
  int n_fail  = 0;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_err     (cfg_err),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .match       (match),
    .busy        (busy),
    .done        (done),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 armed, 2 done; bits accepted since last clear, oldest first.
  int                 m_state;
  bit [MAX_LEN-1:0]   m_pat;
  int                 m_len;
  bit                 m_ov;
  int                 m_tgt;
  int                 m_cnt;
  bit                 m_err;
  bit                 hist[$];

  function automatic void model_reset();
    m_state = 0; m_pat = '0; m_len = 1; m_ov = 1'b1; m_tgt = 0; m_cnt = 0; m_err = 1'b0;
    hist.delete();
  endfunction

  // The newest bit must equal pattern bit 0, the k-th previous bit pattern bit k.
  function automatic bit model_hit(bit b);
    if (hist.size() + 1 < m_len) return 1'b0;
    if (b != m_pat[0]) return 1'b0;
    for (int k = 1; k < m_len; k++) begin
      if (hist[hist.size() - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void push_bit(bit b);
    hist.push_back(b);
    if (hist.size() > MAX_LEN - 1) void'(hist.pop_front());
  endfunction

  function automatic void model_step(bit acc, bit hitm);
    int prev = m_state;
    bit nerr = 1'b0;
    if (cfg_we && prev != 1) begin
      if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap; m_tgt = int'(cfg_target);
      end else begin
        nerr = 1'b1;
      end
    end
    m_err = nerr;
    if (prev == 1) begin
      if (abort) begin
        m_state = 0;
      end else if (hitm) begin
        if (m_cnt < CNT_SAT) m_cnt++;
        if (m_ov) push_bit(in_bit);
        else hist.delete();
        if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
      end else if (acc) begin
        push_bit(in_bit);
      end
    end else if (start && !abort) begin
      m_state = 1; m_cnt = 0; hist.delete();
    end
  endfunction

  // Per-cycle comparison on the falling edge, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    bit acc;
    bit exp_m;
    if (!rstn) model_reset();
    acc   = rstn && (m_state == 1) && in_valid;
    exp_m = acc && !abort && model_hit(in_bit);
    chk("m_match", match, exp_m);
    chk("m_busy", busy, m_state == 1);
    chk("m_in_ready", in_ready, m_state == 1);
    chk("m_done", done, m_state == 2);
    chk("m_count", match_count, m_cnt);
    chk("m_cfg_err", cfg_err, m_err);
    if (rstn) model_step(acc, exp_m);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] p, input int l, input logic ov, input int t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = ov; cfg_target = CNT_W'(t);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_m, input string name);
    in_valid = 1'b1; in_bit = b;
    #2;
    chk(name, match, exp_m);
    tick();
    in_valid = 1'b0;
  endtask

  // Sends n bits, first bit taken from position n-1, with matching expected match flags.
  task automatic send_seq(input logic [15:0] bits, input logic [15:0] exps, input int n, input string name);
    for (int i = n - 1; i >= 0; i--) send(bits[i], exps[i], name);
  endtask

  initial begin
    int r;
    rstn = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_in_ready", in_ready, 0);
    chk("rst_count", match_count, 0); chk("rst_cfg_err", cfg_err, 0);
    tick();

    // Overlapping 110
    do_cfg(8'b110, 3, 1'b1, 0);
    do_start();
    send_seq(16'b110110, 16'b001001, 6, "ovl110_match");
    chk("ovl110_count", match_count, 2); chk("ovl110_busy", busy, 1);

    // 1011 with and without overlap
    do_abort();
    do_cfg(8'b1011, 4, 1'b1, 0);
    do_start();
    send_seq(16'b1011011, 16'b0001001, 7, "ov1011_match");
    chk("ov1011_count", match_count, 2);
    do_abort();
    do_cfg(8'b1011, 4, 1'b0, 0);
    do_start();
    send_seq(16'b1011011, 16'b0001000, 7, "nov1011_match");
    chk("nov1011_count", match_count, 1);

    // Target stop
    do_abort();
    do_cfg(8'b11, 2, 1'b1, 2);
    do_start();
    send_seq(16'b111, 16'b011, 3, "tgt_match");
    chk("tgt_done", done, 1); chk("tgt_in_ready", in_ready, 0); chk("tgt_count", match_count, 2);
    send(1'b1, 1'b0, "tgt_bit4_match");
    chk("tgt_count_after", match_count, 2); chk("tgt_done_after", done, 1);

    // Gaps in the stream, then abort alongside a matching bit
    do_cfg(8'b110, 3, 1'b1, 0);
    do_start();
    send(1'b1, 1'b0, "gap_match"); tick();
    send(1'b1, 1'b0, "gap_match"); tick(); tick();
    send(1'b0, 1'b1, "gap_match3"); tick();
    send(1'b1, 1'b0, "gap_match");
    send(1'b1, 1'b0, "gap_match");
    abort = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
    #2 chk("abort_match", match, 0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_count", match_count, 1); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    do_start();
    chk("restart_count", match_count, 0); chk("restart_busy", busy, 1);

    // Config protection
    do_abort();
    cfg_we = 1'b1; cfg_len = '0; cfg_pattern = 8'hFF;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    tick();
    chk("cfg_err_clear", cfg_err, 0);
    do_start();
    send_seq(16'b110, 16'b001, 3, "cfg_kept_match");
    do_cfg(8'b01, 2, 1'b1, 0);
    chk("cfg_armed_err", cfg_err, 0);
    send_seq(16'b110, 16'b001, 3, "cfg_armed_match");

    // Asynchronous reset mid-stream
    in_valid = 1'b1; in_bit = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_in_ready", in_ready, 0); chk("arst_done", done, 0);
    chk("arst_count", match_count, 0); chk("arst_match", match, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_bit = 1'($urandom);
      #2 chk("post_rst_match", match, 0);
      tick();
    end
    in_valid = 1'b0;

    // Counter saturation
    do_cfg(8'b1, 1, 1'b1, 0);
    do_start();
    in_valid = 1'b1; in_bit = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    chk("sat_count", match_count, CNT_SAT); chk("sat_busy", busy, 1);

    // Randomized traffic, checked by the per-cycle model
    do_abort();
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      cfg_we      = (r < 4);
      cfg_pattern = 8'($urandom);
      cfg_len     = ($urandom_range(0, 9) < 8) ? LW'($urandom_range(1, 4)) : LW'($urandom_range(0, 9));
      cfg_overlap = 1'($urandom);
      cfg_target  = CNT_W'($urandom_range(0, 4));
      start       = (r >= 4 && r < 10);
      abort       = (r == 10 || r == 11);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_bit      = 1'($urandom);
      rstn        = ($urandom_range(0, 999) != 0);
      tick();
    end
    rstn = 1'b1; cfg_we = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
